// File: rtl/quad_tx_exciter.sv
// quad_tx_exciter: one-hot 4-phase LO exciter with PTT/guard/symbol/tail sequencing
module quad_tx_exciter #(
  parameter int SYM_LEN   = 64,
  parameter int GUARD_LEN = 16
) (
  input  logic       if_clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic [1:0] sym_data,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic [3:0] quad_out,
  output logic       ptt,
  output logic       tx_active,
  output logic       underrun
);
  typedef enum logic [1:0] {IDLE, GUARD, RUN, TAIL} state_t;
  localparam logic [15:0] SYM_LAST   = 16'(SYM_LEN - 1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_LEN - 1);
  state_t      state, state_n;
  logic [1:0]  lo_cnt, lo_n, phase, phase_n;
  logic [15:0] sym_cnt, sym_cnt_n, guard_cnt, guard_cnt_n;
  logic        boundary, guard_last, sym_end, underrun_n;
  assign lo_n       = lo_cnt + 2'd1;
  assign boundary   = lo_cnt == 2'd3;
  assign guard_last = guard_cnt == GUARD_LAST;
  assign sym_end    = sym_cnt == SYM_LAST;
  assign sym_ready  = tx_en & boundary & ((state == GUARD & guard_last) | (state == RUN & sym_end));
  assign ptt        = state != IDLE;
  assign tx_active  = state == RUN;
  // every state/counter change is gated to the LO boundary so no runt pulses reach the switches
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    sym_cnt_n   = sym_cnt;
    guard_cnt_n = guard_cnt;
    underrun_n  = 1'b0;
    if (boundary)
      case (state)
        IDLE:
          if (tx_en) begin
            state_n     = GUARD;
            guard_cnt_n = '0;
          end
        GUARD:
          if (!guard_last) guard_cnt_n = guard_cnt + 16'd1;
          else if (!tx_en) begin
            state_n     = TAIL;
            guard_cnt_n = '0;
          end else if (sym_valid) begin
            state_n   = RUN;
            phase_n   = sym_data;
            sym_cnt_n = '0;
          end
        RUN:
          if (!sym_end) sym_cnt_n = sym_cnt + 16'd1;
          else begin
            sym_cnt_n = '0;
            if (!tx_en) begin
              state_n     = TAIL;
              guard_cnt_n = '0;
              phase_n     = '0;
            end else if (sym_valid) phase_n = sym_data;
            else underrun_n = 1'b1;
          end
        TAIL:
          if (guard_last) state_n = IDLE;
          else guard_cnt_n = guard_cnt + 16'd1;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge if_clk) begin
    if (reset) begin
      lo_cnt    <= '0;
      state     <= IDLE;
      phase     <= '0;
      sym_cnt   <= '0;
      guard_cnt <= '0;
      quad_out  <= '0;
      underrun  <= 1'b0;
    end else begin
      lo_cnt    <= lo_n;
      state     <= state_n;
      phase     <= phase_n;
      sym_cnt   <= sym_cnt_n;
      guard_cnt <= guard_cnt_n;
      quad_out  <= state_n == RUN ? 4'b0001 << 2'(lo_n + phase_n) : 4'b0000;
      underrun  <= underrun_n;
    end
  end
endmodule

// File: tb/tb_quad_tx_exciter.sv
// tb_quad_tx_exciter: directed scoreboard bench for quad_tx_exciter (4/2 and 1/1 variants)
module tb_quad_tx_exciter;
  logic       if_clk = 0, reset = 1;
  logic       tx_en = 0, sym_valid = 0, tx_en2 = 0, sym_valid2 = 0;
  logic [1:0] sym_data = 0, sym_data2 = 0;
  logic       sym_ready, ptt, tx_active, underrun;
  logic       sym_ready2, ptt2, tx_active2, underrun2;
  logic [3:0] quad_out, quad2;
  int         passed = 0, total = 0, ur_seen = 0, n, pulses;
  logic [1:0] lo_b = 0, cur_ph = 0, prev, e;
  logic       acc = 0;
  logic [1:0] sb[$];
  logic [1:0] seq [3] = '{2'd2, 2'd3, 2'd0};

  always #5 if_clk = ~if_clk;

  quad_tx_exciter #(.SYM_LEN(4), .GUARD_LEN(2)) dut (
    .if_clk(if_clk), .reset(reset), .tx_en(tx_en), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .quad_out(quad_out), .ptt(ptt), .tx_active(tx_active), .underrun(underrun));

  quad_tx_exciter #(.SYM_LEN(1), .GUARD_LEN(1)) dut2 (
    .if_clk(if_clk), .reset(reset), .tx_en(tx_en2), .sym_data(sym_data2), .sym_valid(sym_valid2),
    .sym_ready(sym_ready2), .quad_out(quad2), .ptt(ptt2), .tx_active(tx_active2), .underrun(underrun2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
  endtask

  // one clock; accepted symbols go to the scoreboard and are checked on the following edge
  task automatic step();
    logic push, r;
    logic [1:0] d, s;
    push = sym_ready && sym_valid;
    d = sym_data;
    r = reset;
    if (sym_ready) chk("rdy_on_boundary", 8'(lo_b), 8'd3);
    if (push) sb.push_back(d);
    @(posedge if_clk);
    #1;
    lo_b = r ? 2'd0 : lo_b + 2'd1;
    acc = push;
    if (push) begin
      cur_ph = sb.pop_front();
      chk("sym_phase", 8'(quad_out), 8'(4'b0001 << cur_ph));
    end
    s = lo_b + cur_ph;
    if (tx_active) chk("onehot_run", 8'(quad_out), 8'(4'b0001 << s));
    if (underrun) ur_seen++;
  endtask

  task automatic send(input logic [1:0] d);
    int k = 0;
    sym_data = d;
    sym_valid = 1;
    acc = 0;
    while (!acc && k < 24) begin
      step();
      k++;
    end
    chk("send_accept", 8'(acc), 8'd1);
  endtask

  initial begin
    reset = 1;
    repeat (3) step();
    chk("rst_out", 8'({quad_out, ptt, tx_active, underrun, sym_ready}), 8'd0);
    chk("rst_out2", 8'({quad2, ptt2, tx_active2, underrun2, sym_ready2}), 8'd0);
    reset = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      chk("idle_out", 8'({quad_out, ptt, sym_ready}), 8'd0);
      chk("lo_wrap", 8'(dut.lo_cnt), 8'(i % 4));
    end
    tx_en = 1;
    sym_valid = 1;
    sym_data = 0;
    n = 0;
    while (!ptt && n < 8) begin
      step();
      n++;
    end
    chk("ptt_latency", 8'(n), 8'd4);
    for (int i = 0; i < 8; i++) begin
      chk("guard_silent", 8'({ptt, quad_out, tx_active}), 8'({1'b1, 4'b0000, 1'b0}));
      step();
    end
    chk("run_entry", 8'({quad_out, tx_active}), 8'({4'b0001, 1'b1}));
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      if (sym_ready) pulses++;
      step();
    end
    chk("rdy_pulses", 8'(pulses), 8'd2);
    send(2'd1);
    chk("phase1", 8'(quad_out), 8'h2);
    send(2'd2);
    chk("phase2", 8'(quad_out), 8'h4);
    send(2'd3);
    chk("phase3", 8'(quad_out), 8'h8);
    sym_valid = 0;
    n = 0;
    while (!underrun && n < 24) begin
      step();
      n++;
    end
    chk("underrun_seen", 8'(underrun), 8'd1);
    chk("underrun_align", 8'(lo_b), 8'd0);
    chk("underrun_repeat", 8'(quad_out), 8'h8);
    step();
    chk("underrun_width", 8'(underrun), 8'd0);
    send(2'd1);
    chk("recover", 8'(quad_out), 8'h2);
    repeat (5) step();
    tx_en = 0;
    for (int i = 0; i < 11; i++) begin
      chk("unkey_run", 8'(tx_active), 8'd1);
      if (i == 10) chk("unkey_no_rdy", 8'(sym_ready), 8'd0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      chk("tail", 8'({ptt, quad_out, tx_active}), 8'({1'b1, 4'b0000, 1'b0}));
      step();
    end
    chk("idle_after_tail", 8'({ptt, quad_out, tx_active}), 8'd0);
    chk("underrun_count", 8'(ur_seen), 8'd1);
    tx_en = 1;
    sym_valid = 1;
    sym_data = 2;
    n = 0;
    while (!tx_active && n < 40) begin
      step();
      n++;
    end
    chk("rekey", 8'(tx_active), 8'd1);
    repeat (6) step();
    reset = 1;
    step();
    chk("rst_mid", 8'({quad_out, ptt, tx_active, underrun, sym_ready}), 8'd0);
    reset = 0;
    tx_en = 0;
    tx_en2 = 1;
    sym_valid2 = 1;
    sym_data2 = 1;
    repeat (4) step();
    chk("v_guard", 8'({ptt2, quad2, tx_active2}), 8'({1'b1, 4'b0000, 1'b0}));
    repeat (3) step();
    chk("v_rdy_first", 8'(sym_ready2), 8'd1);
    step();
    chk("v_entry", 8'({quad2, tx_active2}), 8'({4'b0010, 1'b1}));
    prev = 1;
    foreach (seq[j]) begin
      sym_data2 = seq[j];
      step();
      e = prev + 2'd1;
      chk("v_mid", 8'(quad2), 8'(4'b0001 << e));
      chk("v_rdy_off", 8'(sym_ready2), 8'd0);
      repeat (2) step();
      chk("v_rdy", 8'(sym_ready2), 8'd1);
      step();
      chk("v_sym", 8'(quad2), 8'(4'b0001 << seq[j]));
      prev = seq[j];
    end
    tx_en2 = 0;
    repeat (4) step();
    chk("v_tail", 8'({ptt2, quad2, tx_active2}), 8'({1'b1, 4'b0000, 1'b0}));
    repeat (4) step();
    chk("v_idle", 8'({ptt2, quad2}), 8'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
